pwm_breath_ctrl: RTL and testbench

- Sequencer that drives the configuration inputs (FREQ_Cnt_Set, Chn_duty_Set) of one perip_PWM channel, e.g. a "breathing" LED_R/G/B or a buzzer envelope.
- Ramps duty up to a ceiling, holds, ramps down to zero, holds, then repeats while enabled.
- Keeps its own period timer, which is aligned to the PWM period, so duty changes occur only at period boundaries and produce no mid-period glitches.
- Sits between the top-level template and perip_PWM, in place of the constant configuration values.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_period_timer.sv | 40 ++++
 rtl/pwm_breath_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pwm_breath_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel controllers: state encoding,
// default counter width and the shortest period the PWM can run.
package pwm_pkg;

  localparam int PWM_CNT_W  = 32;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HI   = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LO   = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running period timer aligned to the PWM period. Counts 0..period-1
// while run is high and flags the last cycle of every period with a
// registered PERIOD_END. Held at zero while run is low.
module pwm_period_timer
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] count,
  output logic             PERIOD_END
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_next;

  // Next count: wrap at the end of the period, park at zero when stopped.
  always_comb begin
    count_next = '0;
    if (run && (count < period - ONE)) begin
      count_next = count + ONE;
    end
  end

  // Counter register; PERIOD_END is raised for the cycle the count sits at period-1.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      count      <= '0;
      PERIOD_END <= 1'b0;
    end else begin
      count      <= count_next;
      PERIOD_END <= run && (count_next == period - ONE);
    end
  end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing sequencer for one perip_PWM channel. Latches a clamped config
// when enabled, then ramps the duty up to the ceiling, dwells, ramps down to
// zero, dwells and repeats. Duty and state only move on the cycle after a
// period boundary, so the PWM never sees a mid-period change.
module pwm_breath_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_W  = PWM_CNT_W,
  parameter int HOLD_W = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              EN,
  input  logic [CNT_W-1:0]  PERIOD_SET,
  input  logic [CNT_W-1:0]  DUTY_MAX,
  input  logic [CNT_W-1:0]  STEP,
  input  logic [HOLD_W-1:0] HOLD_PERIODS,
  output logic [CNT_W-1:0]  FREQ_Cnt_Set,
  output logic [CNT_W-1:0]  Chn_duty_Set,
  output logic              PERIOD_END,
  output logic [2:0]        STATE,
  output logic              BUSY
);

  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  P_MIN    = CNT_W'(MIN_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  p_q, m_q, s_q;
  logic [HOLD_W-1:0] h_q;
  logic [CNT_W-1:0]  duty_q, duty_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q;
  logic              load_cfg;

  logic [CNT_W-1:0]  p_lat, m_lat, s_lat;
  logic [CNT_W:0]    sum, diff;
  logic [CNT_W-1:0]  up_val, down_val;
  logic [CNT_W-1:0]  timer_count;
  logic              timer_end;
  logic              tick;

  pwm_period_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .run        (state_q != ST_IDLE),
    .period     (p_q),
    .count      (timer_count),
    .PERIOD_END (timer_end)
  );

  // Clamp incoming config and form the saturating up/down duty steps.
  always_comb begin
    p_lat    = (PERIOD_SET < P_MIN) ? P_MIN : PERIOD_SET;
    m_lat    = (DUTY_MAX > p_lat) ? p_lat : DUTY_MAX;
    s_lat    = (STEP == '0) ? ONE : STEP;
    sum      = {1'b0, duty_q} + {1'b0, s_q};
    diff     = {1'b0, duty_q} - {1'b0, s_q};
    up_val   = (sum >= {1'b0, m_q}) ? m_q : sum[CNT_W-1:0];
    down_val = diff[CNT_W] ? '0 : diff[CNT_W-1:0];
    tick     = timer_end && (timer_count == p_q - ONE);
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, duty and dwell counter; everything outside IDLE waits for a period boundary.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    hold_d   = hold_q;
    load_cfg = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN) begin
          load_cfg = 1'b1;
          duty_d   = '0;
          hold_d   = '0;
          state_d  = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (tick) begin
          if (!EN) begin
            duty_d  = '0;
            state_d = ST_IDLE;
          end else begin
            duty_d = up_val;
            if (up_val == m_q) begin
              if (h_q == '0) begin
                state_d = ST_RAMP_DOWN;
              end else begin
                hold_d  = h_q;
                state_d = ST_HOLD_HI;
              end
            end
          end
        end
      end
      ST_HOLD_HI: begin
        if (tick) begin
          if (!EN) begin
            duty_d  = '0;
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - HOLD_ONE;
            if (hold_q == HOLD_ONE) begin
              state_d = ST_RAMP_DOWN;
            end
          end
        end
      end
      ST_RAMP_DOWN: begin
        if (tick) begin
          if (!EN) begin
            duty_d  = '0;
            state_d = ST_IDLE;
          end else begin
            duty_d = down_val;
            if (down_val == '0) begin
              if (h_q == '0) begin
                state_d = ST_RAMP_UP;
              end else begin
                hold_d  = h_q;
                state_d = ST_HOLD_LO;
              end
            end
          end
        end
      end
      ST_HOLD_LO: begin
        if (tick) begin
          hold_d = hold_q - HOLD_ONE;
          if (hold_q == HOLD_ONE) begin
            state_d = EN ? ST_RAMP_UP : ST_IDLE;
          end
        end
      end
      default: begin
        duty_d  = '0;
        hold_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: duty, dwell counter, busy flag and the latched config.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      duty_q <= '0;
      hold_q <= '0;
      busy_q <= 1'b0;
      p_q    <= '0;
      m_q    <= '0;
      s_q    <= '0;
      h_q    <= '0;
    end else begin
      duty_q <= duty_d;
      hold_q <= hold_d;
      busy_q <= (state_d != ST_IDLE);
      if (load_cfg) begin
        p_q <= p_lat;
        m_q <= m_lat;
        s_q <= s_lat;
        h_q <= HOLD_PERIODS;
      end
    end
  end

  // Output mapping straight from registers.
  always_comb begin
    FREQ_Cnt_Set = p_q;
    Chn_duty_Set = duty_q;
    PERIOD_END   = timer_end;
    STATE        = state_q;
    BUSY         = busy_q;
  end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Self-checking bench for pwm_breath_ctrl. Expected per-period duty/state
// sequences come from a period-level model of the breath shape (ramp up,
// top dwell, ramp down, bottom dwell) built with plain arithmetic.
module tb_pwm_breath_ctrl;

  localparam int CNT_W  = 32;
  localparam int HOLD_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [CNT_W-1:0]  period_set;
  logic [CNT_W-1:0]  duty_max;
  logic [CNT_W-1:0]  step;
  logic [HOLD_W-1:0] hold_periods;
  logic [CNT_W-1:0]  freq_cnt;
  logic [CNT_W-1:0]  chn_duty;
  logic              period_end;
  logic [2:0]        state;
  logic              busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int duty;
    int st;
  } period_t;

  period_t exp_q[$];

  pwm_breath_ctrl #(.CNT_W(CNT_W), .HOLD_W(HOLD_W)) dut (
    .CLK          (clk),
    .RST_n        (rst_n),
    .EN           (en),
    .PERIOD_SET   (period_set),
    .DUTY_MAX     (duty_max),
    .STEP         (step),
    .HOLD_PERIODS (hold_periods),
    .FREQ_Cnt_Set (freq_cnt),
    .Chn_duty_Set (chn_duty),
    .PERIOD_END   (period_end),
    .STATE        (state),
    .BUSY         (busy)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // Build the expected per-period (duty, state) list for a run with EN held high.
  task automatic build_model(input int m, input int s, input int h, input int min_len);
    int d;
    period_t e;
    exp_q.delete();
    while (exp_q.size() < min_len) begin
      d = 0;
      do begin
        e.duty = d; e.st = 1; exp_q.push_back(e);
        d = (d + s > m) ? m : d + s;
      end while (d != m);
      for (int i = 0; i < h; i++) begin
        e.duty = m; e.st = 2; exp_q.push_back(e);
      end
      do begin
        e.duty = d; e.st = 3; exp_q.push_back(e);
        d = (d > s) ? d - s : 0;
      end while (d != 0);
      for (int i = 0; i < h; i++) begin
        e.duty = 0; e.st = 4; exp_q.push_back(e);
      end
    end
  endtask

  // Reset with EN high, then release and confirm the config is latched on the next edge.
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    period_set = 4; duty_max = 3; step = 1; hold_periods = 1;
    repeat (3) @(negedge clk);
    checks++; if (chn_duty !== '0) begin errors++; $display("[TB] FAIL reset duty: got %0d want 0", chn_duty); end
    checks++; if (freq_cnt !== '0) begin errors++; $display("[TB] FAIL reset freq: got %0d want 0", freq_cnt); end
    checks++; if (period_end !== 1'b0) begin errors++; $display("[TB] FAIL reset period_end: got %0b want 0", period_end); end
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset state: got %0d want 0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %0b want 0", busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL release state: got %0d want 0", state); end
    @(negedge clk);
    checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL latch state: got %0d want 1", state); end
    checks++; if (freq_cnt !== 32'd4) begin errors++; $display("[TB] FAIL latch freq: got %0d want 4", freq_cnt); end
    en = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset drain state: got %0d want 0", state); end
    checks++; if (chn_duty !== '0) begin errors++; $display("[TB] FAIL reset drain duty: got %0d want 0", chn_duty); end
  endtask

  // One breath run: start, follow the model period by period, drop EN at a chosen cycle, then check IDLE.
  task automatic test_breath_run(input string name, input int pset, input int dmax, input int stp,
                                 input int hold, input int dis_period, input int dis_cycle, input bit scramble);
    int p, m, s, k, dc;
    bit idle_next;
    period_t e;
    p  = (pset < 2) ? 2 : pset;
    m  = (dmax > p) ? p : dmax;
    s  = (stp == 0) ? 1 : stp;
    dc = dis_cycle % p;
    build_model(m, s, hold, dis_period + hold + 4);
    period_set = pset; duty_max = dmax; step = stp; hold_periods = HOLD_W'(hold);
    en = 1'b1;
    @(posedge clk);
    if (scramble) begin
      #1;
      period_set   = 20;
      duty_max     = $urandom_range(0, 40);
      step         = $urandom_range(0, 7);
      hold_periods = $urandom_range(0, 3);
    end
    @(negedge clk);
    k = 0;
    idle_next = 1'b0;
    while (!idle_next) begin
      e = exp_q[k];
      for (int c = 0; c < p; c++) begin
        checks++; if (chn_duty !== CNT_W'(e.duty)) begin errors++; $display("[TB] FAIL %s duty p%0d c%0d: got %0d want %0d", name, k, c, chn_duty, e.duty); end
        checks++; if (state !== 3'(e.st)) begin errors++; $display("[TB] FAIL %s state p%0d c%0d: got %0d want %0d", name, k, c, state, e.st); end
        checks++; if (period_end !== (c == p - 1)) begin errors++; $display("[TB] FAIL %s period_end p%0d c%0d: got %0b want %0b", name, k, c, period_end, (c == p - 1)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s busy p%0d c%0d: got %0b want 1", name, k, c, busy); end
        checks++; if (freq_cnt !== CNT_W'(p)) begin errors++; $display("[TB] FAIL %s freq p%0d c%0d: got %0d want %0d", name, k, c, freq_cnt, p); end
        if (k == dis_period && c == dc) en = 1'b0;
        @(negedge clk);
      end
      if (k >= dis_period) idle_next = !(exp_q[k].st == 4 && exp_q[k + 1].st == 4);
      k++;
    end
    for (int c = 0; c < 4; c++) begin
      checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL %s idle state c%0d: got %0d want 0", name, c, state); end
      checks++; if (chn_duty !== '0) begin errors++; $display("[TB] FAIL %s idle duty c%0d: got %0d want 0", name, c, chn_duty); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s idle busy c%0d: got %0b want 0", name, c, busy); end
      checks++; if (period_end !== 1'b0) begin errors++; $display("[TB] FAIL %s idle period_end c%0d: got %0b want 0", name, c, period_end); end
      checks++; if (freq_cnt !== CNT_W'(p)) begin errors++; $display("[TB] FAIL %s idle freq c%0d: got %0d want %0d", name, c, freq_cnt, p); end
      @(negedge clk);
    end
  endtask

  // Randomized configs, including clamped periods, zero step and zero ceiling.
  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_breath_run("random", $urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 5),
                      $urandom_range(0, 2), $urandom_range(2, 14), $urandom_range(0, 11), 1'($urandom_range(0, 1)));
    end
  endtask

  // Reset asserted between clock edges must clear the outputs without a clock.
  task automatic test_async_reset();
    period_set = 10; duty_max = 6; step = 2; hold_periods = 1;
    en = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (chn_duty !== 32'd2) begin errors++; $display("[TB] FAIL async pre duty: got %0d want 2", chn_duty); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (chn_duty !== '0) begin errors++; $display("[TB] FAIL async duty: got %0d want 0", chn_duty); end
    checks++; if (freq_cnt !== '0) begin errors++; $display("[TB] FAIL async freq: got %0d want 0", freq_cnt); end
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL async state: got %0d want 0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async busy: got %0b want 0", busy); end
    checks++; if (period_end !== 1'b0) begin errors++; $display("[TB] FAIL async period_end: got %0b want 0", period_end); end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL async post state: got %0d want 0", state); end
  endtask

  // Scenario sequence.
  initial begin
    rst_n = 1'b0; en = 1'b0;
    period_set = '0; duty_max = '0; step = '0; hold_periods = '0;
    test_reset();
    test_breath_run("basic",      10, 4,  2, 1, 9, 9, 1'b1);
    test_breath_run("saturation", 10, 5,  3, 0, 7, 5, 1'b0);
    test_breath_run("clamping",   1,  50, 0, 0, 8, 1, 1'b0);
    test_breath_run("disable",    10, 8,  2, 1, 2, 2, 1'b0);
    test_breath_run("zero_max",   6,  0,  2, 1, 5, 3, 1'b0);
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
